opb_reg_bank_arbiter: RTL

Address-decoding OPB slave controller that shares one OPB slave attachment among C_NUM_SLAVES software-register slaves (opb_register_ppc2simulink class). It sequences each OPB transaction: it decodes, forwards to exactly one downstream register, waits for its ack, returns data, and bounds the wait with a timeout that yields errAck. It sits between the OPB bus and a group of register cores in the same OPB_Clk domain.

---
 rtl/opb_reg_bank_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/opb_reg_bank_arbiter.sv
// OPB slave front end that decodes one address window into C_NUM_SLAVES register
// slots, forwards each transfer to one slot and returns its ack, or errAck on timeout.
module opb_reg_bank_arbiter #(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0000,
  parameter int          C_NUM_SLAVES = 4,
  parameter int          C_SLV_AWIDTH = 8,
  parameter int          C_TIMEOUT    = 12
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:31]                 OPB_ABus,
  input  logic [0:3]                  OPB_BE,
  input  logic [0:31]                 OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:31]                 Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  output logic [C_NUM_SLAVES-1:0]     M_select,
  output logic [0:31]                 M_ABus,
  output logic [0:31]                 M_DBus,
  output logic [0:3]                  M_BE,
  output logic                        M_RNW,
  input  logic [32*C_NUM_SLAVES-1:0]  S_DBus,
  input  logic [C_NUM_SLAVES-1:0]     S_xferAck
);

  localparam int          IDX_W        = (C_NUM_SLAVES > 1) ? $clog2(C_NUM_SLAVES) : 1;
  localparam logic [32:0] BANK_SIZE    = 33'(C_NUM_SLAVES) << C_SLV_AWIDTH;
  localparam logic [7:0]  TIMEOUT_LAST = 8'(C_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_ERR
  } state_t;

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [C_NUM_SLAVES-1:0]   m_select_d;
  logic [0:31]               m_abus_d, m_dbus_d, sl_dbus_d;
  logic [0:3]                m_be_d;
  logic                      m_rnw_d;
  logic                      sl_xferack_d, sl_errack_d, sl_toutsup_d;

  // Burst hints are accepted but have no effect on single-beat sequencing.
  logic unused;
  assign unused = OPB_seqAddr;

  assign Sl_retry = 1'b0;

  // Address decode on the raw bus; the [0:31] to [31:0] copy keeps the numeric value.
  logic [31:0]             addr, offset;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic [C_NUM_SLAVES-1:0] decode_onehot;

  assign addr     = OPB_ABus;
  assign offset   = addr - C_BASEADDR;
  assign in_range = (addr >= C_BASEADDR) && ({1'b0, offset} < BANK_SIZE);
  assign idx      = IDX_W'(offset >> C_SLV_AWIDTH);

  always_comb begin
    for (int i = 0; i < C_NUM_SLAVES; i++) begin
      decode_onehot[i] = (idx == IDX_W'(i));
    end
  end

  // Only the slot currently selected may answer; acks and data from others are masked.
  logic        ack_hit;
  logic [0:31] rd_data;

  assign ack_hit = |(S_xferAck & M_select);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < C_NUM_SLAVES; i++) begin
      if (M_select[i]) rd_data = rd_data | S_DBus[32*i +: 32];
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    m_select_d   = M_select;
    m_abus_d     = M_ABus;
    m_dbus_d     = M_DBus;
    m_be_d       = M_BE;
    m_rnw_d      = M_RNW;
    sl_dbus_d    = '0;
    sl_xferack_d = 1'b0;
    sl_errack_d  = 1'b0;
    sl_toutsup_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        m_select_d = '0;
        if (OPB_select && in_range) begin
          state_d      = ST_WAIT;
          m_select_d   = decode_onehot;
          m_abus_d     = OPB_ABus;
          m_dbus_d     = OPB_DBus;
          m_be_d       = OPB_BE;
          m_rnw_d      = OPB_RNW;
          cnt_d        = '0;
          sl_toutsup_d = 1'b1;
        end
      end

      ST_WAIT: begin
        sl_toutsup_d = 1'b1;
        if (!OPB_select) begin
          // Master abort outranks a coincident slave ack.
          state_d      = ST_IDLE;
          m_select_d   = '0;
          sl_toutsup_d = 1'b0;
        end else if (ack_hit) begin
          state_d      = ST_ACK;
          m_select_d   = '0;
          sl_xferack_d = 1'b1;
          sl_dbus_d    = M_RNW ? rd_data : '0;
          sl_toutsup_d = 1'b0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d      = ST_ERR;
          m_select_d   = '0;
          sl_xferack_d = 1'b1;
          sl_errack_d  = 1'b1;
          sl_toutsup_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // ACK and ERR only last one cycle; select is ignored to force a turnaround.
      ST_ACK: begin
        state_d    = ST_IDLE;
        m_select_d = '0;
      end

      ST_ERR: begin
        state_d    = ST_IDLE;
        m_select_d = '0;
      end

      default: begin
        state_d    = ST_IDLE;
        m_select_d = '0;
      end
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (OPB_Rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      M_select   <= '0;
      M_ABus     <= '0;
      M_DBus     <= '0;
      M_BE       <= '0;
      M_RNW      <= 1'b0;
      Sl_DBus    <= '0;
      Sl_xferAck <= 1'b0;
      Sl_errAck  <= 1'b0;
      Sl_toutSup <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      M_select   <= m_select_d;
      M_ABus     <= m_abus_d;
      M_DBus     <= m_dbus_d;
      M_BE       <= m_be_d;
      M_RNW      <= m_rnw_d;
      Sl_DBus    <= sl_dbus_d;
      Sl_xferAck <= sl_xferack_d;
      Sl_errAck  <= sl_errack_d;
      Sl_toutSup <= sl_toutsup_d;
    end
  end

endmodule
